dual_prio_grant_decoder: RTL
============================

# dual_prio_grant_decoder

Sequential consumer of the dual priority encoder's output pair. Accepts a (first, second) 4-bit priority index pair over a valid/ready handshake and decodes each index back to a 12-bit one-hot grant. It issues the grants one at a time, first then second, each held until acknowledged. It sits between the dual priority encoder and the 12 requesters, turning encoded priorities into serialized grant strobes.

## Interface
- `NUM_REQ`, 12: number of requesters / grant vector width.
- `IDX_W`, 4: index width.
- `TIMEOUT_CYCLES`, 16: grant hold limit; used only with `DUAL_PRIO_TIMEOUT_EN`.
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  index pair present.
- `i_first_prio`  in  IDX_W  highest-priority index.
- `i_second_prio`  in  IDX_W  second-priority index.
- `o_ready`  out  1  block can capture a pair.
- `o_grant`  out  NUM_REQ  one-hot grant; all zero when no grant is active.
- `o_grant_idx`  out  IDX_W  index of the active grant.
- `o_grant_valid`  out  1  grant active.
- `i_grant_ack`  in  1  requester accepts the active grant.
- `o_timeout`  out  1  one-cycle pulse when a grant is dropped unacknowledged (tied 0 without the macro).

## Operation
- Index values 0..11 are real requests. Values 12..15 are null, meaning no request.
- FSM states: IDLE, GRANT_FIRST, GRANT_SECOND.
- **IDLE**
  - `o_ready`=1.
  - On `i_valid`&`o_ready`, register both indices.
  - First index non-null → GRANT_FIRST.
  - Else second index non-null → GRANT_SECOND.
  - Else stay IDLE. The pair is consumed and no grant is issued.
- **GRANT_FIRST**
  - `o_grant_valid`=1, `o_grant`=1<<first, `o_grant_idx`=first.
  - On `i_grant_ack`: if second is non-null and differs from first → GRANT_SECOND; else → IDLE.
- **GRANT_SECOND**: same outputs using the second index. On `i_grant_ack` → IDLE.
- `o_ready`=0 in both grant states. `i_valid` is ignored there, and the upstream must hold its pair.
- `i_grant_ack` is ignored when `o_grant_valid`=0.
- `o_grant` is never multi-hot, and is zero whenever `o_grant_valid`=0.
- All outputs are registered from FSM state and the captured indices.
- Reset values: `o_ready`=1, `o_grant`=0, `o_grant_idx`=0, `o_grant_valid`=0, `o_timeout`=0. State=IDLE, captured indices=0.

## Timing
- Pair captured at edge N → grant visible after edge N (cycle N+1).
- Ack sampled at edge M → next grant (or `o_ready`=1) visible in cycle M+1. There is no bubble between first and second grants.
- Best-case throughput is one pair per 3 cycles: capture, ack1, ack2.
- Ack may arrive in the first cycle a grant is valid.
- An all-null pair costs one capture cycle. `o_ready` stays 1 and no grant is issued.
- Reset asserted mid-grant: the grant is abandoned and all outputs take reset values after that edge. The pending second grant is lost.

## Configuration
- `DUAL_PRIO_TIMEOUT_EN` defined:
  - A per-grant counter clears on grant entry and increments each unacknowledged cycle.
  - When the count reaches `TIMEOUT_CYCLES`-1 without ack, the grant is dropped and `o_timeout` pulses one cycle.
  - The FSM then proceeds exactly as if acked: first grant → second grant or IDLE; second grant → IDLE.
  - Ack and timeout in the same cycle: ack wins and there is no pulse.
- Undefined: no counter; grants are held indefinitely; `o_timeout` is constant 0.

## Structure
- Shared package `dual_prio_pkg` holds:
  - `NUM_REQ`=12, `IDX_W`=4, `NULL_IDX_MIN`=12;
  - the FSM state encoding;
  - an `is_null(idx)` helper.
- One sub-module, `dual_prio_onehot_decode`: a 4→12 combinational index-to-one-hot decoder, producing zero for null indices. It is instantiated once, driven by the active index mux.

## Test plan
- Pair (3,7), ack held high → `o_grant`=0x008 for one cycle, then 0x080 for one cycle, then `o_ready`=1; 3 cycles total.
- Pair (5,5) → single grant 0x020. After ack, go to IDLE; no second grant.
- Pair (15,2) → first grant skipped; `o_grant`=0x004 with `o_grant_idx`=2. Pair (12,14) → no grant, `o_ready` stays 1.
- Pair (0,11), ack withheld 10 cycles → 0x001 held steady, `o_ready`=0, a second `i_valid` pair is ignored. Then ack → 0x800 next cycle.
- Reset asserted while 0x040 is granted → next cycle `o_grant`=0, `o_grant_valid`=0, `o_ready`=1. A subsequent pair (1,2) behaves normally.
- With `DUAL_PRIO_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4: pair (4,6), no ack → `o_grant`=0x010 for 4 cycles, then `o_timeout` pulses, then `o_grant`=0x040 for 4 cycles, then a second pulse, then IDLE.

Source files
------------

// File: rtl/dual_prio_grant_decoder_pkg.sv
// Shared constants, FSM encoding and null-index helper for the
// dual-priority grant decoder.
package dual_prio_pkg;

    localparam int NUM_REQ      = 12;
    localparam int IDX_W        = 4;
    localparam int NULL_IDX_MIN = 12;

    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [NUM_REQ-1:0] grant_t;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_GRANT_FIRST  = 2'd1,
        ST_GRANT_SECOND = 2'd2
    } state_t;

    // Indices at or above NULL_IDX_MIN carry no request.
    function automatic logic is_null(idx_t idx);
        return idx >= IDX_W'(NULL_IDX_MIN);
    endfunction

endpackage

// File: rtl/dual_prio_grant_decoder_if.sv
// Index-pair handshake and grant bus between the priority encoder,
// the grant decoder and the requesters.
interface dual_prio_grant_decoder_if;
    import dual_prio_pkg::*;

    logic   i_valid;
    idx_t   i_first_prio;
    idx_t   i_second_prio;
    logic   o_ready;
    grant_t o_grant;
    idx_t   o_grant_idx;
    logic   o_grant_valid;
    logic   i_grant_ack;
    logic   o_timeout;

    modport master (
        output i_valid,
        output i_first_prio,
        output i_second_prio,
        output i_grant_ack,
        input  o_ready,
        input  o_grant,
        input  o_grant_idx,
        input  o_grant_valid,
        input  o_timeout
    );

    modport slave (
        input  i_valid,
        input  i_first_prio,
        input  i_second_prio,
        input  i_grant_ack,
        output o_ready,
        output o_grant,
        output o_grant_idx,
        output o_grant_valid,
        output o_timeout
    );

endinterface

// File: rtl/dual_prio_grant_decoder_onehot_decode.sv
// Index to one-hot grant decoder; null indices (12..15) decode to zero
// because they match no requester position.
module dual_prio_onehot_decode
    import dual_prio_pkg::*;
(
    input  idx_t   i_idx,
    output grant_t o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_onehot[i] = (i_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/dual_prio_grant_decoder.sv
// Serialises a (first, second) priority index pair into one-hot grants.
// Optional grant hold limit: define DUAL_PRIO_TIMEOUT_EN.
module dual_prio_grant_decoder
    import dual_prio_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    dual_prio_grant_decoder_if.slave   io_bus
);

    state_t r_state;
    state_t w_state_nxt;
    idx_t   r_first;
    idx_t   r_second;
    idx_t   w_act_idx;
    grant_t w_onehot;
    logic   w_grant_valid;
    logic   w_adv;
    logic   w_timeout;

    assign w_grant_valid = (r_state != ST_IDLE);
    assign w_adv = w_grant_valid && (io_bus.i_grant_ack || w_timeout);
    assign w_act_idx = (r_state == ST_GRANT_SECOND) ? r_second : r_first;

`ifdef DUAL_PRIO_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    // An ack in the limit cycle takes precedence over the drop.
    assign w_timeout = w_grant_valid && !io_bus.i_grant_ack
                    && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
            if (w_adv || !w_grant_valid) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign io_bus.o_timeout = r_timeout;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
    assign io_bus.o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_first  <= '0;
            r_second <= '0;
        end else if (r_state == ST_IDLE && io_bus.i_valid) begin
            r_first  <= io_bus.i_first_prio;
            r_second <= io_bus.i_second_prio;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (io_bus.i_valid) begin
                    if (!is_null(io_bus.i_first_prio)) begin
                        w_state_nxt = ST_GRANT_FIRST;
                    end else if (!is_null(io_bus.i_second_prio)) begin
                        w_state_nxt = ST_GRANT_SECOND;
                    end
                end
            end
            ST_GRANT_FIRST: begin
                // A duplicate second index would re-grant the same requester.
                if (w_adv) begin
                    if (!is_null(r_second) && r_second != r_first) begin
                        w_state_nxt = ST_GRANT_SECOND;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GRANT_SECOND: begin
                if (w_adv) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    dual_prio_onehot_decode u_decode (
        .i_idx    (w_act_idx),
        .o_onehot (w_onehot)
    );

    always_comb begin
        io_bus.o_ready       = 1'b0;
        io_bus.o_grant_valid = 1'b0;
        io_bus.o_grant       = '0;
        io_bus.o_grant_idx   = '0;
        unique case (r_state)
            ST_IDLE: begin
                io_bus.o_ready = 1'b1;
            end
            ST_GRANT_FIRST, ST_GRANT_SECOND: begin
                io_bus.o_grant_valid = 1'b1;
                io_bus.o_grant       = w_onehot;
                io_bus.o_grant_idx   = w_act_idx;
            end
            default: begin
                io_bus.o_ready = 1'b0;
            end
        endcase
    end

endmodule
